// File: rtl/univ_rotate_seq.sv
// Command sequencer for a universal rotate register: loads a word, issues rotate
// commands, then checks the register's q against an internally computed expected value.
module univ_rotate_seq #(
  parameter  int DW = 4,
  localparam int AW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          start,
  input  logic          dir,
  input  logic [AW-1:0] amt,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] q_in,
  output logic [1:0]    ctrl,
  output logic [DW-1:0] data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] exp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [1:0] CTRL_LOAD = 2'b00;
  localparam logic [1:0] CTRL_ROR  = 2'b01;
  localparam logic [1:0] CTRL_ROL  = 2'b10;
  localparam logic [1:0] CTRL_HOLD = 2'b11;

  // Rotate through a doubled word; n is always below DW here.
  function automatic logic [DW-1:0] rotate(input logic [DW-1:0] x, input logic right,
                                           input int n);
    logic [2*DW-1:0] w;
    w = right ? ({x, x} >> n) : ({x, x} << n);
    return right ? w[DW-1:0] : w[2*DW-1:DW];
  endfunction

  state_t        r_state;
  logic [1:0]    r_ctrl;
  logic [DW-1:0] r_data;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [DW-1:0] r_exp;
  logic          r_dir;
  logic [AW-1:0] r_amt;
  logic [AW-1:0] r_count;

  logic [DW-1:0] w_exp_next;

  // The register wraps every DW commands, so amt >= DW reduces modulo DW.
  assign w_exp_next = rotate(din, dir, int'(amt) % DW);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_state <= S_IDLE;
      r_ctrl  <= CTRL_HOLD;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_exp   <= '0;
      r_dir   <= 1'b0;
      r_amt   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_LOAD;
            r_ctrl  <= CTRL_LOAD;
            r_data  <= din;
            r_dir   <= dir;
            r_amt   <= amt;
            r_exp   <= w_exp_next;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (r_amt != '0) begin
            r_state <= S_SHIFT;
            r_ctrl  <= r_dir ? CTRL_ROR : CTRL_ROL;
            r_count <= r_amt;
          end else begin
            r_state <= S_CHECK;
            r_ctrl  <= CTRL_HOLD;
          end
        end
        S_SHIFT: begin
          if (r_count == AW'(1)) begin
            r_state <= S_CHECK;
            r_ctrl  <= CTRL_HOLD;
            r_count <= '0;
          end else begin
            r_count <= r_count - AW'(1);
          end
        end
        S_CHECK: begin
          // Every command has been applied by the register at this point.
          r_err   <= (q_in != r_exp);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ctrl  <= CTRL_HOLD;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl = r_ctrl;
  assign data = r_data;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
  assign exp  = r_exp;

endmodule

// File: tb/tb_univ_rotate_seq.sv
// Directed bench for univ_rotate_seq with a behavioural rotate register on its
// ctrl/data interface and a queue of expected job results.
module tb_univ_rotate_seq;

  localparam int DW = 4;
  localparam int AW = 2;

  typedef struct packed {
    logic [DW-1:0] exp;
    logic          err;
  } sb_t;

  logic          clk = 1'b0;
  logic          sync_rst;
  logic          start;
  logic          dir;
  logic [AW-1:0] amt;
  logic [DW-1:0] din;
  logic [DW-1:0] q_in;
  logic [1:0]    ctrl;
  logic [DW-1:0] data;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] exp;

  logic [DW-1:0] reg_q;
  logic          force_en;
  logic [DW-1:0] force_val;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  univ_rotate_seq #(.DW(DW)) dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .start    (start),
    .dir      (dir),
    .amt      (amt),
    .din      (din),
    .q_in     (q_in),
    .ctrl     (ctrl),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .exp      (exp)
  );

  // Behavioural universal rotate register driven by the sequencer.
  always @(posedge clk) begin
    if (sync_rst) reg_q <= '0;
    else begin
      case (ctrl)
        2'b00:   reg_q <= data;
        2'b01:   reg_q <= {reg_q[0], reg_q[DW-1:1]};
        2'b10:   reg_q <= {reg_q[DW-2:0], reg_q[DW-1]};
        default: reg_q <= reg_q;
      endcase
    end
  end

  assign q_in = force_en ? force_val : reg_q;

  function automatic logic [DW-1:0] model_rot(input logic [DW-1:0] x, input logic right,
                                              input int n);
    logic [DW-1:0] v;
    v = x;
    for (int i = 0; i < n; i++)
      v = right ? {v[0], v[DW-1:1]} : {v[DW-2:0], v[DW-1]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_expect(input logic [DW-1:0] d, input logic dr, input logic [AW-1:0] a);
    sb_t e;
    e.exp = model_rot(d, dr, int'(a));
    e.err = force_en && (force_val != e.exp);
    sb_q.push_back(e);
  endtask

  // Called just after the accepting edge; follows the job to its done cycle.
  task automatic wait_job(input string name, input logic [AW-1:0] a, input logic dr,
                          input logic [DW-1:0] d);
    logic [1:0] ec;
    sb_t        e;
    for (int k = 0; k < int'(a) + 2; k++) begin
      @(negedge clk);
      if (k == 0) ec = 2'b00;
      else if (k <= int'(a)) ec = dr ? 2'b01 : 2'b10;
      else ec = 2'b11;
      check($sformatf("%s_ctrl%0d", name, k), 8'(ctrl), 8'(ec));
      check($sformatf("%s_busy%0d", name, k), 8'(busy), 8'd1);
      check($sformatf("%s_nodone%0d", name, k), 8'(done), 8'd0);
      if (k == 0) check($sformatf("%s_data", name), 8'(data), 8'(d));
    end
    @(negedge clk);
    check($sformatf("%s_done", name), 8'(done), 8'd1);
    check($sformatf("%s_idlebusy", name), 8'(busy), 8'd0);
    check($sformatf("%s_donectrl", name), 8'(ctrl), 8'h3);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", name);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("%s_exp", name), 8'(exp), 8'(e.exp));
      check($sformatf("%s_err", name), 8'(err), 8'(e.err));
    end
  endtask

  task automatic launch(input string name, input logic [DW-1:0] d, input logic dr,
                        input logic [AW-1:0] a);
    din   = d;
    dir   = dr;
    amt   = a;
    start = 1'b1;
    push_expect(d, dr, a);
    @(posedge clk);
    #1;
    start = 1'b0;
    din   = ~d;
    dir   = ~dr;
    amt   = ~a;
    wait_job(name, a, dr, d);
  endtask

  initial begin
    sync_rst  = 1'b1;
    start     = 1'b0;
    dir       = 1'b0;
    amt       = '0;
    din       = '0;
    force_en  = 1'b0;
    force_val = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 8'(ctrl), 8'h3);
    check("rst_data", 8'(data), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_done", 8'(done), 8'h0);
    check("rst_err", 8'(err), 8'h0);
    check("rst_exp", 8'(exp), 8'h0);
    sync_rst = 1'b0;
    @(negedge clk);

    launch("rol1", 4'b1001, 1'b0, 2'd1);
    launch("ror3", 4'b0110, 1'b1, 2'd3);

    force_en  = 1'b1;
    force_val = 4'b1011;
    launch("amt0_err", 4'b1010, 1'b0, 2'd0);
    force_en  = 1'b0;
    @(negedge clk);
    check("err_hold", 8'(err), 8'h1);
    launch("err_clear", 4'b0001, 1'b1, 2'd1);

    // Back-to-back: start held through the busy phase and the done cycle.
    din   = 4'b0001;
    dir   = 1'b1;
    amt   = 2'd2;
    start = 1'b1;
    push_expect(4'b0001, 1'b1, 2'd2);
    push_expect(4'b1110, 1'b0, 2'd1);
    @(posedge clk);
    #1;
    din = 4'b1110;
    dir = 1'b0;
    amt = 2'd1;
    wait_job("b2b_a", 2'd2, 1'b1, 4'b0001);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_job("b2b_b", 2'd1, 1'b0, 4'b1110);

    // Start pulsed in SHIFT is ignored; reset in SHIFT aborts with no done.
    din   = 4'b1011;
    dir   = 1'b0;
    amt   = 2'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("abort_load", 8'(ctrl), 8'h0);
    @(negedge clk);
    check("abort_shift1", 8'(ctrl), 8'h2);
    din   = 4'b0000;
    dir   = 1'b1;
    amt   = 2'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("abort_shift2", 8'(ctrl), 8'h2);
    check("abort_exp", 8'(exp), 8'(model_rot(4'b1011, 1'b0, 3)));
    sync_rst = 1'b1;
    @(posedge clk);
    #1;
    sync_rst = 1'b0;
    @(negedge clk);
    check("abort_ctrl", 8'(ctrl), 8'h3);
    check("abort_busy", 8'(busy), 8'h0);
    check("abort_exp0", 8'(exp), 8'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("abort_nodone%0d", i), 8'(done), 8'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
